seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master issues requests and reads results; the slave is the divider.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Results and flags are registered and held until the next accepted start.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave io_bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Control and result registers
    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_dbz;
    logic [DW-1:0]    r_quot;
    logic [WIDTH-1:0] r_rem_out;

    // Working datapath: partial remainder, dividend/quotient shifter, divisor
    logic [WIDTH:0]   r_rem;
    logic [DW-1:0]    r_dvd;
    logic [WIDTH-1:0] r_dsr;

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_step;
    logic             w_qbit;
    logic [WIDTH:0]   w_rem_next;
    logic [DW-1:0]    w_dvd_next;

    // One restoring iteration: returns {quotient bit, new partial remainder}.
    function automatic logic [WIDTH+1:0] restore_step(
        input logic [WIDTH:0]   shifted,
        input logic [WIDTH-1:0] dsr
    );
        logic [WIDTH:0] ext_dsr;
        ext_dsr = {1'b0, dsr};
        if (shifted >= ext_dsr)
            return {1'b1, shifted - ext_dsr};
        else
            return {1'b0, shifted};
    endfunction

    assign w_accept = io_bus.start && (r_state == S_IDLE);
    assign w_zero   = (io_bus.divisor == '0);
    assign w_last   = (r_cnt == '0);

    // Partial remainder stays below the divisor, so the WIDTH+1-bit shift cannot lose bits.
    assign w_shift    = (r_rem << 1) | {{WIDTH{1'b0}}, r_dvd[DW-1]};
    assign w_step     = restore_step(w_shift, r_dsr);
    assign w_qbit     = w_step[WIDTH+1];
    assign w_rem_next = w_step[WIDTH:0];
    assign w_dvd_next = {r_dvd[DW-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dvd <= io_bus.dividend;
            r_dsr <= io_bus.divisor;
            r_rem <= '0;
        end else if (r_state == S_RUN) begin
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_quot    <= '0;
            r_rem_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (io_bus.start) begin
                    r_dbz <= 1'b0;
                    if (w_zero) begin
                        r_quot    <= '1;
                        r_rem_out <= io_bus.dividend[WIDTH-1:0];
                        r_dbz     <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt   <= CW'(DW - 1);
                        r_state <= S_RUN;
                    end
                end
            end else begin
                if (w_last) begin
                    r_quot    <= w_dvd_next;
                    r_rem_out <= w_rem_next[WIDTH-1:0];
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign io_bus.busy        = (r_state == S_RUN);
    assign io_bus.done        = r_done;
    assign io_bus.div_by_zero = r_dbz;
    assign io_bus.quotient    = r_quot;
    assign io_bus.remainder   = r_rem_out;

    // Invariants of the restoring loop
    a_rem_below_dsr : assert property (@(posedge clk) disable iff (rst)
        (r_state == S_RUN) |-> (r_rem < {1'b0, r_dsr}));
    a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
        !(r_done && (r_state == S_RUN)));
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4) against an arithmetic reference model.
module tb_seq_divider;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(WIDTH)) bus();
    seq_divider #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = 8'hFF;
            r = a[3:0];
        end else begin
            q = 8'(ai / bi);
            r = 4'(ai % bi);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Samples at negedges until done; lat counts negedges waited, bc counts busy samples.
    task automatic wait_done(output int lat, output int bc, output bit ok);
        lat = 0;
        bc  = 0;
        ok  = 1'b0;
        while (!ok && lat <= 40) begin
            if (bus.done === 1'b1) ok = 1'b1;
            else begin
                if (bus.busy === 1'b1) bc++;
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.quotient !== 8'd0) $display("FAIL reset_q got %0d want 0", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 4'd0) $display("FAIL reset_r got %0d want 0", bus.remainder); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; int bc; bit ok;
        issue(8'd200, 4'd7);
        wait_done(lat, bc, ok);
        n_total++; if (!ok || lat != 8) $display("FAIL basic_latency got %0d want 8 (ok=%0b)", lat, ok); else n_pass++;
        n_total++; if (bc != 8) $display("FAIL basic_busy_cycles got %0d want 8", bc); else n_pass++;
        n_total++; if (bus.quotient !== 8'd28) $display("FAIL basic_q got %0d want 28", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 4'd4) $display("FAIL basic_r got %0d want 4", bus.remainder); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL basic_dbz got %b want 0", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", bus.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.quotient !== 8'd28) $display("FAIL basic_q_hold got %0d want 28", bus.quotient); else n_pass++;
    endtask

    task automatic test_corners();
        logic [7:0] ta [4];
        logic [3:0] tb [4];
        logic [7:0] eq; logic [3:0] er;
        int lat; int bc; bit ok;
        ta[0] = 8'd255; tb[0] = 4'd1;
        ta[1] = 8'd15;  tb[1] = 4'd15;
        ta[2] = 8'd3;   tb[2] = 4'd9;
        ta[3] = 8'd225; tb[3] = 4'd15;
        for (int i = 0; i < 4; i++) begin
            model(ta[i], tb[i], eq, er);
            issue(ta[i], tb[i]);
            wait_done(lat, bc, ok);
            n_total++; if (!ok || bus.quotient !== eq) $display("FAIL corner_q %0d/%0d got %0d want %0d", ta[i], tb[i], bus.quotient, eq); else n_pass++;
            n_total++; if (bus.remainder !== er) $display("FAIL corner_r %0d/%0d got %0d want %0d", ta[i], tb[i], bus.remainder, er); else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        int lat; int bc; bit ok;
        issue(8'd5, 4'd0);
        wait_done(lat, bc, ok);
        n_total++; if (!ok || lat != 0) $display("FAIL dz_latency got %0d want 0 (ok=%0b)", lat, ok); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL dz_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.quotient !== 8'd255) $display("FAIL dz_q got %0d want 255", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 4'd5) $display("FAIL dz_r got %0d want 5", bus.remainder); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL dz_after busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_hold got %b want 1", bus.div_by_zero); else n_pass++;
        issue(8'd10, 4'd3);
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL dz_clear_on_start got %b want 0", bus.div_by_zero); else n_pass++;
        wait_done(lat, bc, ok);
        n_total++; if (!ok || bus.quotient !== 8'd3) $display("FAIL dz_next_q got %0d want 3", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 4'd1) $display("FAIL dz_next_r got %0d want 1", bus.remainder); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; int bc; bit ok;
        issue(8'd200, 4'd7);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        n_total++; if (bus.quotient !== 8'd3 || bus.remainder !== 4'd1) $display("FAIL midrun_hold got %0d r%0d want 3 r1", bus.quotient, bus.remainder); else n_pass++;
        wait_done(lat, bc, ok);
        n_total++; if (!ok || bus.quotient !== 8'd28) $display("FAIL ignore_q got %0d want 28", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 4'd4) $display("FAIL ignore_r got %0d want 4", bus.remainder); else n_pass++;
        issue(8'd9, 4'd2);
        wait_done(lat, bc, ok);
        n_total++; if (!ok || lat != 8) $display("FAIL b2b_latency got %0d want 8", lat); else n_pass++;
        n_total++; if (bus.quotient !== 8'd4 || bus.remainder !== 4'd1) $display("FAIL b2b_result got %0d r%0d want 4 r1", bus.quotient, bus.remainder); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat; int bc; bit ok;
        int seen;
        issue(8'd200, 4'd7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) $display("FAIL arst_flags got %b want 000", {bus.busy, bus.done, bus.div_by_zero}); else n_pass++;
        n_total++; if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0) $display("FAIL arst_outputs got %0d r%0d want 0 r0", bus.quotient, bus.remainder); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL arst_no_done got %0d active samples want 0", seen); else n_pass++;
        issue(8'd100, 4'd9);
        wait_done(lat, bc, ok);
        n_total++; if (!ok || bus.quotient !== 8'd11 || bus.remainder !== 4'd1) $display("FAIL arst_next got %0d r%0d want 11 r1", bus.quotient, bus.remainder); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] eq; logic [3:0] er;
        logic [7:0] a; logic [3:0] b;
        int lat; int bc; bit ok;
        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                a = 8'(n);
                b = 4'(d);
                model(a, b, eq, er);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                issue(a, b);
                wait_done(lat, bc, ok);
                n_total++;
                if (!ok || lat != 8 || bus.quotient !== eq || bus.remainder !== er || bus.remainder >= b)
                    $display("FAIL exhaustive %0d/%0d got %0d r%0d lat %0d want %0d r%0d lat 8", a, b, bus.quotient, bus.remainder, lat, eq, er);
                else n_pass++;
            end
        end
        for (int k = 0; k < 64; k++) begin
            a = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            if (k % 8 == 0) b = 4'd0;
            model(a, b, eq, er);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b);
            wait_done(lat, bc, ok);
            n_total++;
            if (!ok || lat != ((b == 0) ? 0 : 8) || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== (b == 0))
                $display("FAIL random %0d/%0d got %0d r%0d dbz %b lat %0d want %0d r%0d", a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, eq, er);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
